// File: rtl/fifo_sync_flex.sv
// Single-clock FIFO with occupancy count, programmable almost flags, flush,
// sticky overflow/underflow and a choice of registered or fall-through read.
module fifo_sync_flex #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 16,
    parameter int PTR_SIZE = 4,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter bit FWFT     = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                wr_en,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic                rd_en,
    output logic [WIDTH-1:0]    rd_data,
    output logic                rd_valid,
    output logic                full,
    output logic                empty,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [PTR_SIZE:0]   count,
    output logic                overflow,
    output logic                underflow
);

    localparam logic [PTR_SIZE:0] DEPTH_C = (PTR_SIZE + 1)'(DEPTH);
    localparam logic [PTR_SIZE:0] AF_C    = (PTR_SIZE + 1)'(AF_LEVEL);
    localparam logic [PTR_SIZE:0] AE_C    = (PTR_SIZE + 1)'(AE_LEVEL);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [PTR_SIZE:0] wr_ptr;
    logic [PTR_SIZE:0] rd_ptr;
    logic              wr_acc;
    logic              rd_acc;

    // Flags come from the registered count only; no same-cycle bypass.
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            if (wr_acc && !rd_acc)
                count <= count + 1'b1;
            else if (!wr_acc && rd_acc)
                count <= count - 1'b1;
            if (wr_en && full)  overflow  <= 1'b1;
            if (rd_en && empty) underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !clear && wr_acc)
            mem[wr_ptr[PTR_SIZE-1:0]] <= wr_data;
    end

    generate
        if (FWFT) begin : g_fwft
            // Head word is presented continuously; rd_en only pops.
            assign rd_data  = mem[rd_ptr[PTR_SIZE-1:0]];
            assign rd_valid = ~empty;
        end else begin : g_std
            logic [WIDTH-1:0] data_p1;
            logic             valid_p1;

            // Read stage: popped word lands one cycle after rd_en.
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_p1  <= '0;
                    valid_p1 <= 1'b0;
                end else if (clear) begin
                    valid_p1 <= 1'b0;
                end else begin
                    valid_p1 <= rd_acc;
                    if (rd_acc) data_p1 <= mem[rd_ptr[PTR_SIZE-1:0]];
                end
            end

            assign rd_data  = data_p1;
            assign rd_valid = valid_p1;
        end
    endgenerate

endmodule

// File: doc/fifo_sync_flex.md
Name: fifo_sync_flex

Overview:
Parametrised single-clock FIFO for the SDRAM controller's command and data queues. Extends the basic synchronous FIFO with:
- an occupancy count and programmable almost-full/almost-empty flags;
- a synchronous flush;
- sticky overflow/underflow error flags;
- a selectable read mode: registered standard read or first-word-fall-through (FWFT).

Sits between the host-side request interface and the SDRAM command scheduler.

Parameters:
WIDTH, 16, data width in bits
DEPTH, 16, number of entries; power of two, >= 4
PTR_SIZE, 4, log2(DEPTH); pointers are PTR_SIZE+1 bits (wrap bit)
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active high
clear  input  1  synchronous flush, active high
wr_en  input  1  write request
wr_data  input  WIDTH  write data
rd_en  input  1  read request (pop)
rd_data  output  WIDTH  read data
rd_valid  output  1  rd_data holds a valid popped/head word
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  PTR_SIZE+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset (rst=1 at clk edge), which overrides everything:
  - wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0.
  - Hence empty=1, full=0, almost_empty=1, almost_full=0.
  - Memory contents are not reset.
- Accept rules (registered state only, no combinational bypass):
  - wr_acc = wr_en & ~full.
  - rd_acc = rd_en & ~empty.
- Write while full is dropped: pointer, memory and count unchanged; overflow set to 1.
- Read while empty is dropped: rd_data unchanged; underflow set to 1.
- overflow and underflow clear only on rst, not on clear.
- Full and reading in the same cycle: the write is still rejected (full is sampled before the pop). Empty and writing: the read is rejected.
- Simultaneous wr_acc and rd_acc: both pointers advance, count unchanged.
- Count update: count <= count + wr_acc - rd_acc. Flags decode combinationally from the registered count.
- Pointers increment modulo 2^(PTR_SIZE+1). Memory is indexed by the low PTR_SIZE bits, so wrap-around is seamless.
- Write latency: a word written at edge N makes empty deassert and count increment after edge N. The word is readable from cycle N+1.
- FWFT=0 (standard read):
  - On rd_acc, rd_data <= mem[rd_ptr] at that edge, and rd_valid=1 for exactly the following cycle.
  - Otherwise rd_valid=0 and rd_data holds its value.
  - Read latency is 1 cycle.
- FWFT=1:
  - rd_data = mem[rd_ptr] combinationally, and rd_valid = ~empty.
  - rd_en acts as acknowledge/pop. The next word appears the cycle after the pop.
  - rd_data is don't-care while rd_valid=0.
- clear=1 at an edge:
  - wr_ptr=rd_ptr=0, count=0, rd_valid=0.
  - Any simultaneous wr_en/rd_en is ignored and does not set overflow/underflow.
  - rd_data holds its value.
- Reset mid-operation: in-flight data is discarded and the FIFO behaves as freshly reset on the next cycle.

Test Plan:
Common configuration: WIDTH=8, DEPTH=8, PTR_SIZE=3, AF_LEVEL=6, AE_LEVEL=2.
1. Fill/drain, FWFT=0:
   - Write 0x10..0x17 on 8 consecutive cycles -> count=8, full=1, almost_full=1 from count 6.
   - Then read 8 times -> rd_data=0x10..0x17, each with rd_valid one cycle after rd_en; empty=1 after the last read; overflow=underflow=0.
2. Overflow/underflow:
   - With the FIFO full, write 0xAA -> count stays 8, overflow=1, 0xAA never read back.
   - Drain, then rd_en on empty -> underflow=1, rd_data unchanged.
   - Assert clear -> both flags stay 1; only rst clears them.
3. Wrap-around plus simultaneous read/write:
   - Hold count=4 and run 20 cycles of wr_en=rd_en=1 with incrementing data -> count stays 4, output sequence strictly in order across pointer wrap, no flag change.
4. FWFT=1:
   - Write 0x55 at edge N -> rd_valid=1 and rd_data=0x55 in cycle N+1 with no rd_en.
   - Write 0x66, then pulse rd_en -> rd_data=0x66 next cycle.
   - Second pop -> rd_valid=0.
5. Flush:
   - With count=5, assert clear together with wr_en=1 -> count=0, empty=1, almost_empty=1, overflow=0.
   - Subsequent write/read of 0x3C returns 0x3C.
6. Reset mid-operation:
   - With count=7 and rd_valid=1, assert rst for one cycle -> next cycle count=0, empty=1, rd_data=0, rd_valid=0, all sticky flags 0.
